// File: rtl/ps2_defs.sv
// Shared PS/2 scan-code constants, decoder state encoding and byte classifiers.
// Pure definitions: no logic, no latency, no flow control.
package ps2_defs;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // Pause sends E1 followed by seven more bytes that must be swallowed.
    localparam logic [2:0] PAUSE_TAIL   = 3'd7;
    localparam logic [3:0] PS2_STOP_IDX = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } dec_state_e;

    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_PFX_EXT) || (b == PS2_PFX_BRK) || (b == PS2_PFX_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 frame receiver: sync, falling-edge detect, 11-bit frame check, idle timeout.
// byte_vld_o pulses one cycle after the stop-bit edge; no backpressure (sink must accept).
module ps2_byte_rx
    import ps2_defs::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic [3:0]             bit_cnt_q;
    logic [8:0]             shift_q;
    logic [TW-1:0]          to_cnt_q;
    logic [7:0]             byte_q;
    logic                   byte_vld_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~clk_s;
    assign byte_o     = byte_q;
    assign byte_vld_o = byte_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            byte_q      <= 8'h00;
            byte_vld_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_s;
            byte_vld_q  <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    if (!data_s) bit_cnt_q <= 4'd1;
                end else if (bit_cnt_q == PS2_STOP_IDX) begin
                    bit_cnt_q <= 4'd0;
                    // Odd parity: the 8 data bits plus parity must hold an odd count of ones.
                    if (data_s && (^shift_q)) begin
                        byte_q     <= shift_q[7:0];
                        byte_vld_q <= 1'b1;
                    end
                end else begin
                    shift_q   <= {data_s, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (to_cnt_q == TO_MAX) begin
                bit_cnt_q <= 4'd0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: make/break/extended/pause handling into a 512-entry key map.
// key_valid pulses 2 clk after the stop-bit edge; no backpressure (consumer must sample the pulse).
module ps2_key_decoder
    import ps2_defs::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT_CYC   = 200000,
    parameter bit REPORT_REPEAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire          PS2_CLK,
    inout  wire          PS2_DATA,
    output logic [511:0] key_down,
    output logic [8:0]   last_change,
    output logic         key_valid
);

    logic [7:0]   rx_byte;
    logic         rx_vld;
    dec_state_e   state_q;
    logic [2:0]   skip_n_q;
    logic [511:0] key_down_q;
    logic [8:0]   last_change_q;
    logic         key_valid_q;
    logic [8:0]   ev_code;
    logic         do_make;
    logic         do_brk;

    ps2_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst),
        .ps2_clk_i  (PS2_CLK),
        .ps2_data_i (PS2_DATA),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld)
    );

    assign key_down    = key_down_q;
    assign last_change = last_change_q;
    assign key_valid   = key_valid_q;

    always_comb begin
        ev_code = {(state_q == ST_EXT) || (state_q == ST_EXTBRK), rx_byte};
        do_make = 1'b0;
        do_brk  = 1'b0;
        if (rx_vld) begin
            case (state_q)
                ST_IDLE, ST_EXT:   do_make = !is_prefix(rx_byte) && !is_ignored(rx_byte);
                ST_BRK, ST_EXTBRK: do_brk  = !is_prefix(rx_byte);
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            skip_n_q      <= 3'd0;
            key_down_q    <= '0;
            last_change_q <= 9'h000;
            key_valid_q   <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (rx_vld) begin
                state_q <= ST_IDLE;
                case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == PS2_PFX_EXT) begin
                            state_q <= ST_EXT;
                        end else if (rx_byte == PS2_PFX_BRK) begin
                            state_q <= ST_BRK;
                        end else if (rx_byte == PS2_PFX_PAUSE) begin
                            state_q  <= ST_SKIP;
                            skip_n_q <= PAUSE_TAIL;
                        end
                    end
                    ST_EXT: begin
                        if (rx_byte == PS2_PFX_BRK) state_q <= ST_EXTBRK;
                    end
                    ST_SKIP: begin
                        if (skip_n_q != 3'd1) begin
                            state_q  <= ST_SKIP;
                            skip_n_q <= skip_n_q - 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
            // A typematic repeat of a held key is reported only when REPORT_REPEAT is set.
            if (do_make && (REPORT_REPEAT || !key_down_q[ev_code])) begin
                key_down_q[ev_code] <= 1'b1;
                last_change_q       <= ev_code;
                key_valid_q         <= 1'b1;
            end
            if (do_brk) begin
                key_down_q[ev_code] <= 1'b0;
                last_change_q       <= ev_code;
                key_valid_q         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a scan-code level reference model and per-cycle compare.
module tb_ps2_key_decoder;

    localparam int TO   = 300;
    localparam int HALF = 8;
    localparam int GAP  = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     = 1'b0;
    logic         ps2c_drv  = 1'b1;
    logic         ps2d_drv  = 1'b1;
    wire          ps2_clk_w;
    wire          ps2_data_w;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         key_valid;

    assign ps2_clk_w  = ps2c_drv;
    assign ps2_data_w = ps2d_drv;

    ps2_key_decoder #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYC   (TO),
        .REPORT_REPEAT (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .PS2_CLK     (ps2_clk_w),
        .PS2_DATA    (ps2_data_w),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid)
    );

    typedef struct {
        logic [8:0]   code;
        logic [511:0] kd;
    } ev_t;

    ev_t          evq[$];
    logic [511:0] m_kd   = '0;
    logic [511:0] cur_kd = '0;
    bit           m_ext  = 1'b0;
    bit           m_brk  = 1'b0;
    int           m_skip = 0;
    int           checks = 0;
    int           errors = 0;
    int           pulses = 0;

    // Reference model: interprets the scan-code byte stream as prefix flags and a pause-skip count.
    function automatic bit is_ign(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    task automatic push_event(input logic [8:0] code, input bit down);
        ev_t e;
        m_kd[code] = down;
        e.code = code;
        e.kd   = m_kd;
        evq.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit pfx;
        pfx = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_brk) begin
            if (!pfx) push_event({m_ext, b}, 1'b0);
            m_ext = 0;
            m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                if (!pfx && !is_ign(b)) push_event({1'b1, b}, 1'b1);
                m_ext = 0;
            end
        end else begin
            if (b == 8'hE0)                 m_ext  = 1;
            else if (b == 8'hF0)            m_brk  = 1;
            else if (b == 8'hE1)            m_skip = 7;
            else if (!is_ign(b))            push_event({1'b0, b}, 1'b1);
        end
    endtask

    task automatic model_reset();
        m_kd   = '0;
        cur_kd = '0;
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
        evq.delete();
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2d_drv = fr[i];
            repeat (HALF) @(negedge clk);
            ps2c_drv = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c_drv = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_bits(mk_frame(b, 1'b0), 11);
        repeat (GAP) @(negedge clk);
    endtask

    // Per-cycle compare against the model's event queue and committed key map.
    initial begin : cmp
        ev_t e;
        bit  prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 0;
                continue;
            end
            checks++;
            if (key_valid) begin
                pulses++;
                if (prev) begin
                    errors++;
                    $display("FAIL back_to_back_valid: key_valid high again, required low");
                end else if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: last_change=%0h, required no event", last_change);
                end else begin
                    e = evq.pop_front();
                    cur_kd = e.kd;
                    if (last_change !== e.code) begin
                        errors++;
                        $display("FAIL event_code: got %0h required %0h", last_change, e.code);
                    end
                    if (key_down !== e.kd) begin
                        errors++;
                        $display("FAIL event_map: got %0h required %0h", key_down, e.kd);
                    end
                end
            end else if (key_down !== cur_kd) begin
                errors++;
                $display("FAIL map_hold: got %0h required %0h", key_down, cur_kd);
            end
            prev = key_valid;
        end
    end

    initial begin : main
        repeat (5) @(negedge clk);
        chk("reset_key_down_any", 64'(|key_down), 64'd0);
        chk("reset_last_change", 64'(last_change), 64'h000);
        chk("reset_key_valid", 64'(key_valid), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'h1C);
        chk("t1_kd_01c", 64'(key_down[9'h01C]), 64'd1);
        chk("t1_last_change", 64'(last_change), 64'h01C);
        chk("t1_pulses", 64'(pulses), 64'd1);

        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t2_kd_01c", 64'(key_down[9'h01C]), 64'd0);
        chk("t2_last_change", 64'(last_change), 64'h01C);
        chk("t2_pulses", 64'(pulses), 64'd2);

        send_byte(8'hE0);
        send_byte(8'h75);
        chk("t3_kd_175_make", 64'(key_down[9'h175]), 64'd1);
        chk("t3_kd_075_make", 64'(key_down[9'h075]), 64'd0);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("t3_kd_175_break", 64'(key_down[9'h175]), 64'd0);
        chk("t3_last_change", 64'(last_change), 64'h175);
        chk("t3_pulses", 64'(pulses), 64'd4);

        send_bits(mk_frame(8'h29, 1'b1), 11);
        repeat (GAP) @(negedge clk);
        chk("t4_bad_parity_pulses", 64'(pulses), 64'd4);
        chk("t4_bad_parity_kd", 64'(key_down[9'h029]), 64'd0);
        send_byte(8'h29);
        chk("t4_kd_029", 64'(key_down[9'h029]), 64'd1);

        send_bits(mk_frame(8'h1B, 1'b0), 4);
        repeat (TO + 10) @(negedge clk);
        send_byte(8'h1B);
        chk("t5_kd_01b", 64'(key_down[9'h01B]), 64'd1);
        chk("t5_last_change", 64'(last_change), 64'h01B);
        chk("t5_keys_held", 64'($countones(key_down)), 64'd2);
        chk("t5_pulses", 64'(pulses), 64'd6);

        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        chk("t6_pause_silent", 64'(pulses), 64'd6);
        send_byte(8'h1C);
        chk("t6_last_change", 64'(last_change), 64'h01C);
        chk("t6_keys_held", 64'($countones(key_down)), 64'd3);
        send_byte(8'h1C);
        chk("t6_repeat_pulses", 64'(pulses), 64'd8);

        send_bits(mk_frame(8'h33, 1'b0), 5);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("t6_rst_key_down_any", 64'(|key_down), 64'd0);
        chk("t6_rst_last_change", 64'(last_change), 64'h000);
        chk("t6_rst_key_valid", 64'(key_valid), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h1C);
        chk("t6_post_rst_kd", 64'(key_down[9'h01C]), 64'd1);
        chk("t6_post_rst_held", 64'($countones(key_down)), 64'd1);
        chk("t6_post_rst_pulses", 64'(pulses), 64'd9);

        chk("events_outstanding", 64'(evq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
